// File: rtl/dmem_bytelane_if.sv
// Request/response bus between the MEM stage and the byte-lane data memory.
interface dmem_bytelane_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        ready;
    logic        rvalid;
    logic [31:0] data_out;
    logic        misalign;
    logic        oob;

    modport master (
        output req, we, size, sign_ext, addr, data_in,
        input  ready, rvalid, data_out, misalign, oob
    );

    modport slave (
        input  req, we, size, sign_ext, addr, data_in,
        output ready, rvalid, data_out, misalign, oob
    );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory: byte/half/word stores with lane merge, sign/zero
// extended sub-word loads with a registered 1-cycle response, misalign and
// out-of-range flags, and a one-word-per-cycle clear sweep after reset.
module dmem_bytelane #(
    parameter int          DEPTH_LOG2     = 11,
    parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_bytelane_if.slave  bus
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    // True when the access does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        mis = ((size == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00));
        return mis;
    endfunction

    // Lanes touched by a store of the given size at the given lane.
    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << lane;
            2'b01:   strb = lane[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Pull the addressed byte/half down to bit 0 and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic sext);
        logic        [31:0] shifted;
        logic signed [7:0]  sbyte;
        logic signed [15:0] shalf;
        logic        [31:0] res;
        shifted = word >> {lane, 3'b000};
        sbyte   = shifted[7:0];
        shalf   = shifted[15:0];
        case (size)
            2'b00:   res = sext ? 32'(sbyte) : {24'b0, shifted[7:0]};
            2'b01:   res = sext ? 32'(shalf) : {16'b0, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    logic [31:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  misalign_q, misalign_d;
    logic                  oob_q, oob_d;
    logic [31:0]           data_out_q, data_out_d;

    logic [31:0]           off;
    logic                  acc_oob;
    logic                  acc_mis;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            lane;
    logic                  accept;
    logic [31:0]           rd_word;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_strb;

    // Address decode: offsets below BASE_ADDR wrap high and land out of range.
    always_comb begin
        off      = bus.addr - BASE_ADDR;
        acc_oob  = (off[31:DEPTH_LOG2+2] != '0);
        word_idx = off[DEPTH_LOG2+1:2];
        lane     = off[1:0];
        acc_mis  = is_misaligned(bus.size, lane);
        acc_err  = acc_oob || acc_mis;
        accept   = bus.req && (state_q == ST_IDLE);
        rd_word  = mem[word_idx];
    end

    // Single write port shared by the clear sweep and lane-merged stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = word_idx;
        mem_wdata = bus.data_in;
        mem_strb  = 4'b0000;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q;
            mem_wdata = 32'b0;
            mem_strb  = 4'b1111;
        end else if (accept && bus.we && !acc_err) begin
            mem_we   = 1'b1;
            mem_strb = store_strobe(bus.size, lane);
            case (bus.size)
                2'b00:   mem_wdata = {4{bus.data_in[7:0]}};
                2'b01:   mem_wdata = {2{bus.data_in[15:0]}};
                default: mem_wdata = bus.data_in;
            endcase
        end
    end

    // Data array: per-lane write enables, no reset on storage.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_strb[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Clear sweep walks every word once, then the block sits in IDLE.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) state_d = ST_IDLE;
        end
    end

    // Response for the request accepted this cycle; data_out holds between loads.
    always_comb begin
        rvalid_d   = accept;
        misalign_d = accept && acc_mis;
        oob_d      = accept && acc_oob;
        data_out_d = data_out_q;
        if (accept && !bus.we) begin
            data_out_d = acc_err ? 32'b0 : extend_load(rd_word, lane, bus.size, bus.sign_ext);
        end
    end

    // Control and response registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RESET;
            clr_cnt_q  <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            oob_q      <= 1'b0;
            data_out_q <= 32'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
            oob_q      <= oob_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.ready    = (state_q == ST_IDLE);
    assign bus.rvalid   = rvalid_q;
    assign bus.misalign = misalign_q;
    assign bus.oob      = oob_q;
    assign bus.data_out = data_out_q;

endmodule
